// File: rtl/mem_port_ctrl.sv
// ----------------------------------------------------------------------------
// mem_port_ctrl
//
// Request-side initiator for the unified instruction/data memory. It accepts
// one core request at a time (load, store or fetch), drives a single memory
// cycle, waits out the memory's registered read latency and returns exactly
// one response. Stores below DATA_BASE and the reserved opcode are rejected
// without touching the memory.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   I_req_valid    core request valid
//   O_req_ready    high only while idle
//   I_req_op       00 load, 01 store, 10 fetch, 11 reserved
//   I_req_addr     word address
//   I_req_wdata    store data
//   O_rsp_valid    response valid, held until I_rsp_ready
//   I_rsp_ready    core accepts the response
//   O_rsp_data     load data / fetched instruction; 0 for store and error
//   O_rsp_err      request was rejected
//   O_mem_en       memory enable
//   O_mem_rd       1 = read-only cycle, 0 = write at O_mem_addr2
//   O_mem_addr1    fetch address
//   O_mem_addr2    data address
//   O_mem_wdata    write data
//   I_mem_inst     memory fetch-port output
//   I_mem_rdata    memory data-port output
// ----------------------------------------------------------------------------
module mem_port_ctrl #(
    parameter int             AW        = 12,
    parameter int             DW        = 32,
    parameter logic [AW-1:0]  DATA_BASE = 12'h400
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          I_req_valid,
    output logic          O_req_ready,
    input  logic [1:0]    I_req_op,
    input  logic [AW-1:0] I_req_addr,
    input  logic [DW-1:0] I_req_wdata,
    output logic          O_rsp_valid,
    input  logic          I_rsp_ready,
    output logic [DW-1:0] O_rsp_data,
    output logic          O_rsp_err,
    output logic          O_mem_en,
    output logic          O_mem_rd,
    output logic [AW-1:0] O_mem_addr1,
    output logic [AW-1:0] O_mem_addr2,
    output logic [DW-1:0] O_mem_wdata,
    input  logic [DW-1:0] I_mem_inst,
    input  logic [DW-1:0] I_mem_rdata
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FETCH = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    op_t           op_q;
    logic [AW-1:0] addr_q;

    op_t  req_op;
    logic req_illegal;

    assign req_op      = op_t'(I_req_op);
    // Unsigned compare: DATA_BASE itself is writable.
    assign req_illegal = (req_op == OP_RSVD) ||
                         ((req_op == OP_STORE) && (I_req_addr < DATA_BASE));

    // All outputs are registered: each output is set on the edge that enters
    // the state in which it must be visible.
    always_ff @(posedge clk) begin
        // NOTE: every register here is reset, including the memory-side
        // outputs, so a reset in ISSUE immediately drops en and restores rd=1.
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_LOAD;
            addr_q      <= '0;
            O_req_ready <= 1'b1;
            O_rsp_valid <= 1'b0;
            O_rsp_data  <= '0;
            O_rsp_err   <= 1'b0;
            O_mem_en    <= 1'b0;
            O_mem_rd    <= 1'b1;
            O_mem_addr1 <= '0;
            O_mem_addr2 <= '0;
            O_mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values regardless of statement order.
            case (state)
                IDLE: begin
                    O_mem_en <= 1'b0;
                    O_mem_rd <= 1'b1;
                    if (I_req_valid) begin
                        op_q        <= req_op;
                        addr_q      <= I_req_addr;
                        O_req_ready <= 1'b0;
                        if (req_illegal) begin
                            // Rejected: no memory cycle, answer straight away.
                            state       <= RESP;
                            O_rsp_valid <= 1'b1;
                            O_rsp_err   <= 1'b1;
                            O_rsp_data  <= '0;
                        end else begin
                            state    <= ISSUE;
                            O_mem_en <= 1'b1;
                            if (req_op == OP_FETCH) begin
                                O_mem_addr1 <= I_req_addr;
                            end else begin
                                O_mem_addr2 <= I_req_addr;
                            end
                            if (req_op == OP_STORE) begin
                                O_mem_rd    <= 1'b0;
                                O_mem_wdata <= I_req_wdata;
                            end
                        end
                    end
                end

                ISSUE: begin
                    // The memory samples en/rd/addr on this edge; close the
                    // cycle so a write can never repeat.
                    state    <= WAIT;
                    O_mem_en <= 1'b0;
                    O_mem_rd <= 1'b1;
                end

                WAIT: begin
                    // Memory outputs updated on the previous edge; take them now.
                    state       <= RESP;
                    O_rsp_valid <= 1'b1;
                    O_rsp_err   <= 1'b0;
                    case (op_q)
                        OP_FETCH: O_rsp_data <= I_mem_inst;
                        OP_LOAD:  O_rsp_data <= I_mem_rdata;
                        default:  O_rsp_data <= '0;
                    endcase
                end

                RESP: begin
                    if (I_rsp_ready) begin
                        state       <= IDLE;
                        O_rsp_valid <= 1'b0;
                        O_rsp_err   <= 1'b0;
                        O_rsp_data  <= '0;
                        O_req_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_port_ctrl
//
// Directed bench for mem_port_ctrl with a behavioural model of the unified
// memory (registered read on both ports, write on en && !rd).
// ----------------------------------------------------------------------------
module tb_mem_port_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          I_req_valid = 1'b0;
    logic          O_req_ready;
    logic [1:0]    I_req_op = 2'b00;
    logic [AW-1:0] I_req_addr = '0;
    logic [DW-1:0] I_req_wdata = '0;
    logic          O_rsp_valid;
    logic          I_rsp_ready = 1'b0;
    logic [DW-1:0] O_rsp_data;
    logic          O_rsp_err;
    logic          O_mem_en;
    logic          O_mem_rd;
    logic [AW-1:0] O_mem_addr1;
    logic [AW-1:0] O_mem_addr2;
    logic [DW-1:0] O_mem_wdata;
    logic [DW-1:0] I_mem_inst = '0;
    logic [DW-1:0] I_mem_rdata = '0;

    mem_port_ctrl #(.AW(AW), .DW(DW), .DATA_BASE(12'h400)) dut (
        .clk         (clk),
        .rst         (rst),
        .I_req_valid (I_req_valid),
        .O_req_ready (O_req_ready),
        .I_req_op    (I_req_op),
        .I_req_addr  (I_req_addr),
        .I_req_wdata (I_req_wdata),
        .O_rsp_valid (O_rsp_valid),
        .I_rsp_ready (I_rsp_ready),
        .O_rsp_data  (O_rsp_data),
        .O_rsp_err   (O_rsp_err),
        .O_mem_en    (O_mem_en),
        .O_mem_rd    (O_mem_rd),
        .O_mem_addr1 (O_mem_addr1),
        .O_mem_addr2 (O_mem_addr2),
        .O_mem_wdata (O_mem_wdata),
        .I_mem_inst  (I_mem_inst),
        .I_mem_rdata (I_mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read on both ports, write when en && !rd.
    logic [DW-1:0] mem [0:4095];

    always @(posedge clk) begin
        if (O_mem_en) begin
            I_mem_inst  <= mem[O_mem_addr1];
            I_mem_rdata <= mem[O_mem_addr2];
            if (!O_mem_rd) mem[O_mem_addr2] <= O_mem_wdata;
        end
    end

    // Bus monitor: counts cycles (sampled just before each edge).
    int            en_cnt  = 0;
    int            wr_cnt  = 0;
    int            rd0_cnt = 0;
    logic [AW-1:0] last_addr1 = '0;
    logic [AW-1:0] last_addr2 = '0;

    always @(posedge clk) begin
        if (O_mem_en) begin
            en_cnt     = en_cnt + 1;
            last_addr1 = O_mem_addr1;
            last_addr2 = O_mem_addr2;
            if (!O_mem_rd) wr_cnt = wr_cnt + 1;
        end
        if (!O_mem_rd) rd0_cnt = rd0_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge, let the next posedge accept it, then
    // count further edges until O_rsp_valid rises (bounded).
    task automatic send_req(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, output int edges);
        edges = 0;
        @(negedge clk);
        I_req_valid = 1'b1;
        I_req_op    = op;
        I_req_addr  = addr;
        I_req_wdata = wd;
        @(negedge clk);
        I_req_valid = 1'b0;
        I_req_op    = OP_RSVD;        // later changes must be ignored
        I_req_addr  = 12'h000;
        I_req_wdata = 32'hFFFF_FFFF;
        while (!O_rsp_valid && edges < 10) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Accept the pending response and confirm return to idle.
    task automatic take_rsp(input string tag);
        I_rsp_ready = 1'b1;
        @(negedge clk);
        I_rsp_ready = 1'b0;
        check({tag, "_valid_clr"}, {31'b0, O_rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, O_req_ready}, 32'd1);
    endtask

    int edges;
    int en0, wr0, rd00;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h001] = 32'h4000_0F83;
        mem[12'h3FF] = 32'h1234_5678;
        mem[12'h400] = 32'd10;
        mem[12'h401] = 32'd20;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'b0, O_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, O_rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, O_rsp_err},   32'd0);
        check("rst_rsp_data",  O_rsp_data,            32'd0);
        check("rst_mem_en",    {31'b0, O_mem_en},    32'd0);
        check("rst_mem_rd",    {31'b0, O_mem_rd},    32'd1);
        check("rst_addr1",     {20'b0, O_mem_addr1}, 32'd0);
        check("rst_addr2",     {20'b0, O_mem_addr2}, 32'd0);
        check("rst_wdata",     O_mem_wdata,           32'd0);

        // Load 0x400 -> 10
        en0 = en_cnt; wr0 = wr_cnt;
        send_req(OP_LOAD, 12'h400, 32'h0, edges);
        check("ld400_latency", edges, 2);
        check("ld400_data",  O_rsp_data, 32'd10);
        check("ld400_err",   {31'b0, O_rsp_err}, 32'd0);
        check("ld400_en_cycles", en_cnt - en0, 1);
        check("ld400_no_write",  wr_cnt - wr0, 0);
        check("ld400_addr2", {20'b0, last_addr2}, 32'h400);
        take_rsp("ld400");

        // Fetch addr 1; I_rsp_ready held high before RESP must not matter
        I_rsp_ready = 1'b1;
        send_req(OP_FETCH, 12'h001, 32'h0, edges);
        check("fetch_latency", edges, 2);
        check("fetch_data",  O_rsp_data, 32'h4000_0F83);
        check("fetch_addr1", {20'b0, last_addr1}, 32'h001);
        @(negedge clk);
        I_rsp_ready = 1'b0;
        check("fetch_valid_clr", {31'b0, O_rsp_valid}, 32'd0);
        check("fetch_ready_back", {31'b0, O_req_ready}, 32'd1);

        // Store 0xDEADBEEF to 0x405, then load it back
        en0 = en_cnt; wr0 = wr_cnt; rd00 = rd0_cnt;
        send_req(OP_STORE, 12'h405, 32'hDEAD_BEEF, edges);
        check("st405_latency", edges, 2);
        check("st405_data", O_rsp_data, 32'd0);
        check("st405_err",  {31'b0, O_rsp_err}, 32'd0);
        check("st405_rd0_cycles", rd0_cnt - rd00, 1);
        check("st405_wr_cycles",  wr_cnt - wr0, 1);
        check("st405_mem", mem[12'h405], 32'hDEAD_BEEF);
        take_rsp("st405");
        send_req(OP_LOAD, 12'h405, 32'h0, edges);
        check("ld405_data", O_rsp_data, 32'hDEAD_BEEF);
        take_rsp("ld405");

        // Store to DATA_BASE itself is legal
        send_req(OP_STORE, 12'h400, 32'd10, edges);
        check("st400_err", {31'b0, O_rsp_err}, 32'd0);
        check("st400_latency", edges, 2);
        take_rsp("st400");

        // Store below DATA_BASE is rejected
        en0 = en_cnt;
        send_req(OP_STORE, 12'h3FF, 32'hCAFE_F00D, edges);
        check("st3ff_latency", edges, 0);
        check("st3ff_err",  {31'b0, O_rsp_err}, 32'd1);
        check("st3ff_data", O_rsp_data, 32'd0);
        check("st3ff_req_ready", {31'b0, O_req_ready}, 32'd0);
        take_rsp("st3ff");
        check("st3ff_no_en", en_cnt - en0, 0);
        check("st3ff_mem", mem[12'h3FF], 32'h1234_5678);

        // Reserved opcode is rejected
        en0 = en_cnt;
        send_req(OP_RSVD, 12'h500, 32'h0, edges);
        check("rsvd_latency", edges, 0);
        check("rsvd_err",  {31'b0, O_rsp_err}, 32'd1);
        check("rsvd_data", O_rsp_data, 32'd0);
        take_rsp("rsvd");
        check("rsvd_no_en", en_cnt - en0, 0);

        // Back-pressure: hold response 5 cycles
        send_req(OP_LOAD, 12'h401, 32'h0, edges);
        check("ld401_latency", edges, 2);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", {31'b0, O_rsp_valid}, 32'd1);
            check("hold_data",  O_rsp_data, 32'd20);
            check("hold_ready", {31'b0, O_req_ready}, 32'd0);
            @(negedge clk);
        end
        take_rsp("ld401");

        // Reset while in WAIT of a load
        @(negedge clk);
        I_req_valid = 1'b1;
        I_req_op    = OP_LOAD;
        I_req_addr  = 12'h400;
        @(negedge clk);                    // now in ISSUE
        I_req_valid = 1'b0;
        check("mid_issue_en", {31'b0, O_mem_en}, 32'd1);
        @(negedge clk);                    // now in WAIT
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {31'b0, O_rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, O_req_ready}, 32'd1);
        check("mid_rst_en",    {31'b0, O_mem_en},    32'd0);
        check("mid_rst_rd",    {31'b0, O_mem_rd},    32'd1);
        check("mid_rst_data",  O_rsp_data,            32'd0);
        check("mid_rst_addr2", {20'b0, O_mem_addr2}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'b0, O_rsp_valid}, 32'd0);
        end
        send_req(OP_LOAD, 12'h400, 32'h0, edges);
        check("post_rst_latency", edges, 2);
        check("post_rst_data", O_rsp_data, 32'd10);
        take_rsp("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d passes of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
